// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - data-port bundle between the datapath MEM stage and the data memory
//
// Purpose : groups the load and store signals of the core's data port.
// Signals : rd_addr/rd_size  load byte address and size (0 byte, 1 half, 2/3 word)
//           rd_data          right-justified, zero-extended load data
//           wr_addr/wr_size  store byte address and size
//           wr_data          right-justified store data
//           wr_enable        a store is presented this cycle
// Modports: slave  - the datapath side (drives addresses, sizes and store data)
//           master - the memory side (drives rd_data)
interface mem_if;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic [31:0] rd_data;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        wr_enable;

  modport master (
    input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    output rd_data
  );

  modport slave (
    output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    input  rd_data
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - data memory with combinational loads and a buffered store path
//
// Purpose : word array of 2^(ADDR_BITS-2) words starting at BASE_ADDR. Stores are queued
//           in a WB_DEPTH-entry write buffer and drained one entry per cycle whenever the
//           array is not needed by a load. Loads are answered in the same cycle.
// Option  : MEM_RESPONDER_FWD_EN - when defined, loads merge pending stores per byte.
//           When undefined, a load that hits a pending word stalls (busy_o) and forces
//           drains until the word is no longer pending.
// Ports   : clk_i      clock
//           reset_i    asynchronous active-high reset (buffer emptied, flag cleared)
//           memif      mem_if.master data port
//           rd_en_i    a load is presented this cycle
//           busy_o     the load cannot be served this cycle; rd_data is 0
//           misalign_o sticky flag, set the cycle after any misaligned access
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          ADDR_BITS = 16,
  parameter int          WB_DEPTH  = 4
) (
  input  logic  clk_i,
  input  logic  reset_i,
  mem_if.master memif,
  input  logic  rd_en_i,
  output logic  busy_o,
  output logic  misalign_o
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lo[0];
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lo;
      SZ_HALF: lane_be = 4'b0011 << lo;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Pointers wrap explicitly so a depth of 1 (one-bit pointer that must stay 0) works too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == WB_DEPTH - 1) ptr_inc = '0;
    else                         ptr_inc = p + 1'b1;
  endfunction

  // Buffer slot holding the i-th oldest pending entry.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] h, input int i);
    slot_of = PTR_W'((int'(h) + i) % WB_DEPTH);
  endfunction

  // Word array; contents survive reset.
  logic [31:0] mem [WORDS];

  // Write buffer.
  logic [IDX_W-1:0] wb_idx  [WB_DEPTH];
  logic [3:0]       wb_be   [WB_DEPTH];
  logic [31:0]      wb_data [WB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0]      rd_off;
  logic [31:0]      wr_off;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in;
  logic             wr_in;
  logic             rd_al;
  logic             wr_al;
  logic             rd_ok;
  logic             push;
  logic             drain;
  logic             full;
  logic             empty;
  logic             hit;
  logic [31:0]      rd_word;
  logic [31:0]      rd_lane;
  logic [31:0]      wr_lane;
  logic [3:0]       wr_be;

  // Address decode. An address is in the window when it lies at or above BASE_ADDR and
  // its offset fits in ADDR_BITS.
  assign rd_off = memif.rd_addr - BASE_ADDR;
  assign wr_off = memif.wr_addr - BASE_ADDR;
  assign rd_in  = (memif.rd_addr >= BASE_ADDR) && ((rd_off >> ADDR_BITS) == 32'd0);
  assign wr_in  = (memif.wr_addr >= BASE_ADDR) && ((wr_off >> ADDR_BITS) == 32'd0);
  assign rd_idx = rd_off[ADDR_BITS-1:2];
  assign wr_idx = wr_off[ADDR_BITS-1:2];
  assign rd_al  = is_aligned(memif.rd_size, memif.rd_addr[1:0]);
  assign wr_al  = is_aligned(memif.wr_size, memif.wr_addr[1:0]);
  assign rd_ok  = rd_al && rd_in;

  // Store data is shifted into its byte lanes; unused upper bytes are masked by wr_be.
  assign wr_lane = memif.wr_data << {memif.wr_addr[1:0], 3'b000};
  assign wr_be   = lane_be(memif.wr_size, memif.wr_addr[1:0]);

  assign full  = (count == CNT_W'(WB_DEPTH));
  assign empty = (count == '0);

  // A full buffer always drains, so a store arriving while full takes the slot the head
  // vacates in the same cycle and is never refused.
  assign push   = ~reset_i && memif.wr_enable && wr_al && wr_in;
  assign busy_o = rd_en_i && (full || (hit && rd_ok));
  assign drain  = ~reset_i && ~empty && (~rd_en_i || busy_o);

  // Array read plus pending-entry scan, oldest first so the youngest write to a byte wins.
  always_comb begin
    rd_word = mem[rd_idx];
    hit     = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((i < int'(count)) && (wb_idx[slot_of(head, i)] == rd_idx)) begin
`ifdef MEM_RESPONDER_FWD_EN
        for (int b = 0; b < 4; b++) begin
          if (wb_be[slot_of(head, i)][b]) begin
            rd_word[8*b +: 8] = wb_data[slot_of(head, i)][8*b +: 8];
          end
        end
`else
        hit = 1'b1;
`endif
      end
    end
  end

  // Right-justify the selected lane and zero-extend it.
  always_comb begin
    rd_lane = rd_word >> {memif.rd_addr[1:0], 3'b000};
    case (memif.rd_size)
      SZ_BYTE: rd_lane = rd_lane & 32'h0000_00FF;
      SZ_HALF: rd_lane = rd_lane & 32'h0000_FFFF;
      default: rd_lane = rd_lane;
    endcase
    memif.rd_data = (rd_ok && !busy_o) ? rd_lane : 32'd0;
  end

  // Buffer control and sticky misalign flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      misalign_o <= 1'b0;
    end else begin
      if (push)  tail <= ptr_inc(tail);
      if (drain) head <= ptr_inc(head);
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((memif.wr_enable && !wr_al) || (rd_en_i && !rd_al)) misalign_o <= 1'b1;
    end
  end

  // Buffer payload and array writes carry no reset. When a push lands on a full buffer
  // the tail slot equals the head slot; the drain below still sees the old head entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      wb_idx[tail]  <= wr_idx;
      wb_be[tail]   <= wr_be;
      wb_data[tail] <= wr_lane;
    end
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[head][b]) begin
          mem[wb_idx[head]][8*b +: 8] <= wb_data[head][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a byte-level store model
module tb_mem_responder;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 4;
`ifdef MEM_RESPONDER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  logic rd_en;
  logic busy;
  logic misalign;

  mem_if memif ();

  mem_responder #(.BASE_ADDR(BASE), .ADDR_BITS(16), .WB_DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .memif     (memif),
    .rd_en_i   (rd_en),
    .busy_o    (busy),
    .misalign_o(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          n;
    logic [31:0] data;
  } st_t;

  st_t         q[$];
  logic [7:0]  mmem [logic [31:0]];
  bit          exp_mis;
  int          n_checks;
  int          n_fail;
  bit          obs_busy;
  logic [31:0] obs_data;

  function automatic int size_n(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit al(input logic [31:0] a, input logic [1:0] s);
    return (a % size_n(s)) == 0;
  endfunction

  function automatic bit inr(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h0001_0000);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A00_0F0F | (i << 16);
  endfunction

  // Byte as a load would see it: array contents, overlaid by pending stores when forwarding.
  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [7:0]  b;
    logic [31:0] t;
    b = mmem.exists(a) ? mmem[a] : 8'hxx;
    if (FWD) begin
      foreach (q[j]) begin
        if (a >= q[j].addr && a < q[j].addr + q[j].n) begin
          t = q[j].data >> (8 * (a - q[j].addr));
          b = t[7:0];
        end
      end
    end
    return b;
  endfunction

  function automatic bit model_busy(input bit re, input logic [31:0] ra, input logic [1:0] rs);
    bit m;
    m = 1'b0;
    if (!FWD && al(ra, rs) && inr(ra)) begin
      foreach (q[j]) if (q[j].addr[31:2] == ra[31:2]) m = 1'b1;
    end
    return re && (q.size() == DEPTH || m);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] ra, input logic [1:0] rs);
    logic [31:0] v;
    v = 32'd0;
    if (al(ra, rs) && inr(ra)) begin
      for (int k = 0; k < size_n(rs); k++) v = v | (32'(model_byte(ra + k)) << (8 * k));
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model, check flag.
  task automatic step(input bit re, input logic [31:0] ra, input logic [1:0] rs,
                      input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [1:0] ws);
    bit          eb;
    logic [31:0] ed;
    logic [31:0] t;
    st_t         e;
    rd_en           = re;
    memif.rd_addr   = ra;
    memif.rd_size   = rs;
    memif.wr_enable = we;
    memif.wr_addr   = wa;
    memif.wr_data   = wd;
    memif.wr_size   = ws;
    #2;
    eb = model_busy(re, ra, rs);
    ed = eb ? 32'd0 : model_load(ra, rs);
    if (re) begin
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("rd_data", memif.rd_data, ed);
    end
    obs_busy = busy;
    obs_data = memif.rd_data;
    if (q.size() > 0 && (!re || eb)) begin
      e = q.pop_front();
      for (int k = 0; k < e.n; k++) begin
        t = e.data >> (8 * k);
        mmem[e.addr + k] = t[7:0];
      end
    end
    if (we && al(wa, ws) && inr(wa)) q.push_back('{addr: wa, n: size_n(ws), data: wd});
    if ((we && !al(wa, ws)) || (re && !al(ra, rs))) exp_mis = 1'b1;
    @(posedge clk);
    #1;
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
  endtask

  task automatic store(input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] ws);
    step(1'b0, 32'd0, 2'd2, 1'b1, wa, wd, ws);
  endtask

  // Present a load until it is served, bounded; the final data is checked against a constant.
  task automatic load_served(input string tag, input logic [31:0] ra, input logic [1:0] rs,
                             input logic [31:0] expc);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, ra, rs, 1'b0, 32'd0, 32'd0, 2'd2);
      if (!obs_busy) break;
    end
    chk({tag, "_served"}, {31'd0, obs_busy}, 32'd0);
    chk(tag, obs_data, expc);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] wa;
    logic [1:0]  rs;
    logic [1:0]  ws;
    n_checks = 0;
    n_fail   = 0;
    exp_mis  = 1'b0;

    // Reset state.
    rst             = 1'b1;
    rd_en           = 1'b1;
    memif.rd_addr   = 32'h0002_0000;
    memif.rd_size   = 2'd2;
    memif.wr_enable = 1'b0;
    memif.wr_addr   = 32'd0;
    memif.wr_data   = 32'd0;
    memif.wr_size   = 2'd2;
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_rd_data", memif.rd_data, 32'd0);
    #8 rst = 1'b0;
    @(posedge clk);
    #1;

    // Initialise the 64-byte working window.
    for (int i = 0; i < 16; i++) store(BASE + 4 * i, init_val(i), 2'd2);
    idle(4);
    load_served("init_w15", BASE + 32'h3C, 2'd2, init_val(15));

    // Word round-trip.
    store(32'h0001_0004, 32'hDEAD_BEEF, 2'd2);
    load_served("t1_word", 32'h0001_0004, 2'd2, 32'hDEAD_BEEF);

    // Byte merge.
    store(32'h0001_0008, 32'h1122_3344, 2'd2);
    store(32'h0001_000A, 32'h0000_00AA, 2'd0);
    idle(3);
    load_served("t2_word", 32'h0001_0008, 2'd2, 32'h11AA_3344);
    load_served("t2_half", 32'h0001_000A, 2'd1, 32'h0000_11AA);

    // Full buffer: four stores while a load is held, then one busy cycle.
    idle(5);
    for (int i = 0; i < 4; i++)
      step(1'b1, BASE + 32'h3C, 2'd2, 1'b1, BASE + 32'h20 + 4 * i, 32'h7700_0000 + i, 2'd2);
    step(1'b1, BASE + 32'h3C, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
    chk("t3_busy_full", {31'd0, obs_busy}, 32'd1);
    step(1'b1, BASE + 32'h3C, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
    chk("t3_busy_after", {31'd0, obs_busy}, 32'd0);
    chk("t3_data_after", obs_data, init_val(15));
    // Store into a full buffer during the forced drain.
    step(1'b1, BASE + 32'h3C, 2'd2, 1'b1, BASE + 32'h34, 32'h0000_5555, 2'd2);
    step(1'b1, BASE + 32'h3C, 2'd2, 1'b1, BASE + 32'h30, 32'h0BAD_C0DE, 2'd2);
    chk("t3_busy_push", {31'd0, obs_busy}, 32'd1);
    idle(6);
    load_served("t3_fifth", BASE + 32'h30, 2'd2, 32'h0BAD_C0DE);
    load_served("t3_first", BASE + 32'h20, 2'd2, 32'h7700_0000);

    // Random aligned traffic inside and just outside the window.
    for (int i = 0; i < 400; i++) begin
      rs = 2'($urandom_range(0, 2));
      ws = 2'($urandom_range(0, 2));
      ra = BASE + ($urandom_range(0, 63) & ~(size_n(rs) - 1));
      wa = BASE + ($urandom_range(0, 63) & ~(size_n(ws) - 1));
      if ($urandom_range(0, 15) == 0) ra = ra + 32'h0001_0000;
      if ($urandom_range(0, 15) == 0) wa = wa - 32'h0000_0040;
      step(1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), wa, $urandom, ws);
    end
    idle(6);

    // Misaligned accesses.
    store(32'h0001_0001, 32'h0000_BEEF, 2'd1);
    chk("t4_misalign_set", {31'd0, misalign}, 32'd1);
    idle(3);
    load_served("t4_word0", BASE, 2'd2, model_load(BASE, 2'd2));
    step(1'b1, 32'h0001_0002, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
    chk("t4_misload_data", obs_data, 32'd0);
    chk("t4_misalign_held", {31'd0, misalign}, 32'd1);
    step(1'b1, 32'h0001_FFFC + 32'h4, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
    chk("t4_oor_data", obs_data, 32'd0);

    // Reset while three stores are pending.
    for (int i = 0; i < 3; i++)
      step(1'b1, BASE, 2'd2, 1'b1, BASE + 32'h14 + 4 * i, 32'hEEEE_0000 + i, 2'd2);
    rd_en           = 1'b1;
    memif.rd_addr   = BASE;
    memif.wr_enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_misalign", {31'd0, misalign}, 32'd0);
    q.delete();
    exp_mis = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, BASE + 32'h14 + 4 * i, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
      chk("t5_not_new", {31'd0, obs_data == 32'hEEEE_0000 + i}, 32'd0);
    end

    // Store followed at once by a load of the same word.
    idle(2);
    store(32'h0001_0010, 32'hCAFE_F00D, 2'd2);
    step(1'b1, 32'h0001_0010, 2'd2, 1'b0, 32'd0, 32'd0, 2'd2);
    chk("t6_first_busy", {31'd0, obs_busy}, {31'd0, !FWD});
    if (obs_busy) load_served("t6_data", 32'h0001_0010, 2'd2, 32'hCAFE_F00D);
    else chk("t6_data", obs_data, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
